sr_ff_checker: RTL and testbench

SR_FF_CHECKER -- requirements
Module: sr_ff_checker

---
 rtl/sr_ff_checker.sv | 103 ++++++++++
 tb/tb_sr_ff_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_checker.sv
// Reference-model checker for an SR flip-flop: tracks the expected state from s/r,
// compares the flop's q/qbar each edge, counts checks and mismatches, halts after MAX_ERR.
module sr_ff_checker #(
  parameter int CNT_W   = 8,
  parameter int MAX_ERR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             err,
  output logic             err_sticky,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic             model_q,
  output logic             model_valid,
  output logic             halted
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A threshold beyond the counter range can never be reached, so halting is disabled.
  localparam bit HALT_EN = (MAX_ERR > 0) &&
                           (longint'(MAX_ERR) <= ((longint'(1) << CNT_W) - 1));
  localparam logic [CNT_W-1:0] MAX_ERR_C = HALT_EN ? CNT_W'(MAX_ERR) : '0;

  logic [1:0]       state;
  logic             mismatch;
  logic [CNT_W-1:0] err_inc, chk_inc;

  // qbar equal to model_q also catches the q==qbar case.
  assign mismatch = (q != model_q) || (qbar == model_q);
  assign err_inc  = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);
  assign chk_inc  = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      illegal     <= 1'b0;
      err_cnt     <= '0;
      chk_cnt     <= '0;
      model_q     <= 1'b0;
      model_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      err     <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (en) state <= ARMED;
        ARMED: begin
          if (!en) begin
            state       <= IDLE;
            model_valid <= 1'b0;
          end else if (s && r) begin
            illegal <= 1'b1;
          end else if (s || r) begin
            model_q     <= s;
            model_valid <= 1'b1;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (!en) begin
            state       <= IDLE;
            model_valid <= 1'b0;
          end else begin
            chk_cnt <= chk_inc;
            if (mismatch) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
              err_cnt    <= err_inc;
            end
            // Compare used the old model_q above; now advance the model.
            if (s && r) begin
              illegal     <= 1'b1;
              model_valid <= 1'b0;
              state       <= ARMED;
            end else if (s || r) begin
              model_q <= s;
            end
            if (HALT_EN && mismatch && (err_inc == MAX_ERR_C)) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ff_checker.sv
// Scoreboard bench for sr_ff_checker: default instance plus a CNT_W=2 instance that
// exercises counter saturation and the unreachable-MAX_ERR case.
module tb_sr_ff_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, s, r, q, qbar;

  logic       err_d, es_d, il_d, mq_d, mv_d, hl_d;
  logic [7:0] ec_d, cc_d;
  logic       err_t, es_t, il_t, mq_t, mv_t, hl_t;
  logic [1:0] ec_t, cc_t;

  sr_ff_checker #(.CNT_W(8), .MAX_ERR(4)) u_d (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
    .err(err_d), .err_sticky(es_d), .illegal(il_d), .err_cnt(ec_d), .chk_cnt(cc_d),
    .model_q(mq_d), .model_valid(mv_d), .halted(hl_d));

  sr_ff_checker #(.CNT_W(2), .MAX_ERR(4)) u_t (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
    .err(err_t), .err_sticky(es_t), .illegal(il_t), .err_cnt(ec_t), .chk_cnt(cc_t),
    .model_q(mq_t), .model_valid(mv_t), .halted(hl_t));

  typedef enum int {M_IDLE, M_ARMED, M_CHECK, M_HALT} mst_t;
  typedef struct {
    mst_t st;
    bit   err, sticky, ill, mq, mv, halted;
    int   ec, cc;
  } mdl_t;

  int   n_tot = 0, n_bad = 0, cyc_n = 0;
  bit   ff_q = 1'b0;
  mdl_t md, mt;
  mdl_t q_d[$], q_t[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, bit rs, bit e, bit si, bit ri, bit qi, bit qbi,
                                 int cmax, int maxe);
    mdl_t n = m;
    n.err = 0;
    n.ill = 0;
    if (rs) begin
      n = '{st: M_IDLE, default: 0};
      return n;
    end
    case (m.st)
      M_IDLE:  if (e) n.st = M_ARMED;
      M_ARMED: begin
        if (!e) begin n.st = M_IDLE; n.mv = 0; end
        else if (si && ri) n.ill = 1;
        else if (si) begin n.mq = 1; n.mv = 1; n.st = M_CHECK; end
        else if (ri) begin n.mq = 0; n.mv = 1; n.st = M_CHECK; end
      end
      M_CHECK: begin
        if (!e) begin n.st = M_IDLE; n.mv = 0; end
        else begin
          n.cc = (m.cc < cmax) ? m.cc + 1 : cmax;
          if (qi != m.mq || qbi != !m.mq) begin
            n.err = 1; n.sticky = 1;
            n.ec = (m.ec < cmax) ? m.ec + 1 : cmax;
          end
          if (si && ri) begin n.ill = 1; n.mv = 0; n.st = M_ARMED; end
          else if (si) n.mq = 1;
          else if (ri) n.mq = 0;
          if (n.err && n.ec == maxe) n.st = M_HALT;
        end
      end
      default: ;
    endcase
    n.halted = (n.st == M_HALT);
    return n;
  endfunction

  task automatic chk_dut(string p, mdl_t e, logic er, logic es, logic il, logic [7:0] ec,
                         logic [7:0] cc, logic mq, logic mv, logic hl);
    chk({p, ".err"},         32'(er), 32'(e.err));
    chk({p, ".err_sticky"},  32'(es), 32'(e.sticky));
    chk({p, ".illegal"},     32'(il), 32'(e.ill));
    chk({p, ".err_cnt"},     32'(ec), e.ec);
    chk({p, ".chk_cnt"},     32'(cc), e.cc);
    chk({p, ".model_q"},     32'(mq), 32'(e.mq));
    chk({p, ".model_valid"}, 32'(mv), 32'(e.mv));
    chk({p, ".halted"},      32'(hl), 32'(e.halted));
  endtask

  // One clock: drive, predict into the queues, then pop and compare after the edge.
  task automatic cyc(bit rs, bit e, bit si, bit ri, bit fq = 0, bit fqb = 0);
    mdl_t x;
    rst = rs; en = e; s = si; r = ri;
    q = ff_q ^ fq; qbar = ~ff_q ^ fqb;
    md = mstep(md, rs, e, si, ri, q, qbar, 255, 4); q_d.push_back(md);
    mt = mstep(mt, rs, e, si, ri, q, qbar, 3, 4);   q_t.push_back(mt);
    @(posedge clk); #1;
    if (si && !ri) ff_q = 1'b1;
    else if (!si && ri) ff_q = 1'b0;
    cyc_n++;
    x = q_d.pop_front();
    chk_dut("d", x, err_d, es_d, il_d, ec_d, cc_d, mq_d, mv_d, hl_d);
    x = q_t.pop_front();
    chk_dut("t", x, err_t, es_t, il_t, {6'b0, ec_t}, {6'b0, cc_t}, mq_t, mv_t, hl_t);
  endtask

  initial begin
    md = '{st: M_IDLE, default: 0};
    mt = '{st: M_IDLE, default: 0};
    rst = 1; en = 0; s = 0; r = 0; q = 0; qbar = 1;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    chk("rst.halted", 32'(hl_d), 0);

    // clean run: 10, 00, 01
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("clean.chk_cnt", 32'(cc_d), 2);
    chk("clean.err_cnt", 32'(ec_d), 0);

    // single forced mismatch
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0, 1);
    chk("mis.err", 32'(err_d), 1);
    chk("mis.err_cnt", 32'(ec_d), 1);
    cyc(0, 1, 0, 0);
    chk("mis.pulse_end", 32'(err_d), 0);
    chk("mis.sticky", 32'(es_d), 1);

    // illegal in CHECK
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    chk("ill.pulse", 32'(il_d), 1);
    chk("ill.valid", 32'(mv_d), 0);
    chk("ill.chk_cnt", 32'(cc_d), 7);
    cyc(0, 1, 0, 0);
    chk("ill.no_cnt", 32'(cc_d), 7);
    chk("sat.chk_cnt", 32'(cc_t), 3);

    // four mismatches -> HALT on the wide instance only
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
    chk("halt.halted", 32'(hl_d), 1);
    chk("halt.err_cnt", 32'(ec_d), 4);
    chk("nohalt.halted", 32'(hl_t), 0);
    chk("nohalt.err_cnt", 32'(ec_t), 3);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 0);
    chk("halt.frozen_ec", 32'(ec_d), 4);
    chk("halt.frozen_cc", 32'(cc_d), 4);

    // reset mid-check with err_cnt=2, then en drop in CHECK
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("mid.err_cnt", 32'(ec_d), 2);
    cyc(1, 1, 1, 0);
    chk("mid.rst_ec", 32'(ec_d), 0);
    chk("mid.rst_es", 32'(es_d), 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("endrop.chk_cnt", 32'(cc_d), 1);
    chk("endrop.valid", 32'(mv_d), 0);

    // randomized traffic through the scoreboard
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
          1'($urandom), 1'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
